// File: rtl/mau_pkg.sv
// rtl/mau_pkg.sv - shared size/state encodings and alignment rule for the memory access unit
package mau_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2,
    SZ_ILL  = 2'd3
  } size_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_WRITE = 3'd2,
    ST_RESP  = 3'd3,
    ST_ERR   = 3'd4
  } state_e;

  function automatic logic misaligned(size_e sz, logic [1:0] off);
    case (sz)
      SZ_BYTE: return 1'b0;
      SZ_HALF: return off[0];
      SZ_WORD: return off != 2'b00;
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/mau_if.sv
// rtl/mau_if.sv - CPU request/response bundle and word-wide data-memory bundle
interface mau_cpu_if;
  logic        req;
  logic        we;
  logic [1:0]  size;
  logic        sext;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        ready;
  logic        done;
  logic        err;
  logic [31:0] rdata;

  modport master (output req, we, size, sext, addr, wdata,
                  input  ready, done, err, rdata);
  modport slave  (input  req, we, size, sext, addr, wdata,
                  output ready, done, err, rdata);
endinterface

interface mau_mem_if #(parameter int ADDR_W = 10);
  logic [ADDR_W-1:0] dm_addr;
  logic [31:0]       dm_din;
  logic              dm_we;
  logic [31:0]       dm_dout;

  modport master (output dm_addr, dm_din, dm_we, input dm_dout);
  modport slave  (input  dm_addr, dm_din, dm_we, output dm_dout);
endinterface

// File: rtl/mau_lane.sv
// rtl/mau_lane.sv - little-endian lane extract/extend for loads and lane merge for stores
module mau_lane
  import mau_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [31:0] wdata_i,
  input  size_e       size_i,
  input  logic        sext_i,
  input  logic [1:0]  off_i,
  output logic [31:0] load_o,
  output logic [31:0] merge_o
);

  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  always_comb begin
    sel_byte = word_i[{off_i, 3'b000} +: 8];
    sel_half = off_i[1] ? word_i[31:16] : word_i[15:0];
    load_o   = word_i;
    merge_o  = word_i;
    case (size_i)
      SZ_BYTE: begin
        load_o = {{24{sext_i & sel_byte[7]}}, sel_byte};
        merge_o[{off_i, 3'b000} +: 8] = wdata_i[7:0];
      end
      SZ_HALF: begin
        load_o = {{16{sext_i & sel_half[15]}}, sel_half};
        if (off_i[1]) merge_o[31:16] = wdata_i[15:0];
        else          merge_o[15:0]  = wdata_i[15:0];
      end
      SZ_WORD: merge_o = wdata_i;
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - load/store sequencer between CPU and a word-wide data memory
module mem_access_unit
  import mau_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input logic          clk,
  input logic          rst,
  mau_cpu_if.slave     cpu,
  mau_mem_if.master    mem
);

  state_e            state_q;
  logic              we_q;
  size_e             size_q;
  logic              sext_q;
  logic [ADDR_W+1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [31:0]       buf_q;
  logic [31:0]       rdata_q;
  logic              ready_q;
  logic              done_q;
  logic              err_q;
  logic              dm_we_q;

  logic [31:0]       load_d;
  logic [31:0]       merge_d;

  // Lane logic sees the live memory word during READ, so the buffer captures it already merged.
  mau_lane u_lane (
    .word_i  (mem.dm_dout),
    .wdata_i (wdata_q),
    .size_i  (size_q),
    .sext_i  (sext_q),
    .off_i   (addr_q[1:0]),
    .load_o  (load_d),
    .merge_o (merge_d)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      we_q    <= 1'b0;
      size_q  <= SZ_BYTE;
      sext_q  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      buf_q   <= '0;
      rdata_q <= '0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      dm_we_q <= 1'b0;
    end else begin
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      dm_we_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (cpu.req) begin
            we_q    <= cpu.we;
            size_q  <= size_e'(cpu.size);
            sext_q  <= cpu.sext;
            addr_q  <= cpu.addr[ADDR_W+1:0];
            wdata_q <= cpu.wdata;
            ready_q <= 1'b0;
            if (misaligned(size_e'(cpu.size), cpu.addr[1:0])) begin
              state_q <= ST_ERR;
              done_q  <= 1'b1;
              err_q   <= 1'b1;
            end else if (cpu.we && size_e'(cpu.size) == SZ_WORD) begin
              buf_q   <= cpu.wdata;
              dm_we_q <= 1'b1;
              done_q  <= 1'b1;
              state_q <= ST_WRITE;
            end else begin
              state_q <= ST_READ;
            end
          end
        end
        ST_READ: begin
          done_q <= 1'b1;
          if (we_q) begin
            buf_q   <= merge_d;
            dm_we_q <= 1'b1;
            state_q <= ST_WRITE;
          end else begin
            buf_q   <= mem.dm_dout;
            rdata_q <= load_d;
            state_q <= ST_RESP;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign cpu.ready   = ready_q;
  assign cpu.done    = done_q;
  assign cpu.err     = err_q;
  assign cpu.rdata   = rdata_q;
  assign mem.dm_addr = addr_q[ADDR_W+1:2];
  assign mem.dm_din  = buf_q;
  assign mem.dm_we   = dm_we_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - scoreboard bench for mem_access_unit with a word-array reference model
module tb_mem_access_unit;

  localparam int AW = 10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mau_cpu_if cpu ();
  mau_mem_if #(.ADDR_W(AW)) mi ();

  mem_access_unit #(.ADDR_W(AW)) dut (
    .clk (clk),
    .rst (rst),
    .cpu (cpu),
    .mem (mi)
  );

  logic [31:0] mem     [1024];
  logic [31:0] ref_mem [1024];

  assign mi.dm_dout = mem[mi.dm_addr];
  always @(negedge clk) if (mi.dm_we) mem[mi.dm_addr] <= mi.dm_din;

  typedef struct {
    int          kind;
    logic [31:0] widx;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  exp_t        q[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          last_done = -10;
  logic [31:0] ref_rdata = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic model(logic w, logic [1:0] sz, logic sx, logic [31:0] a, logic [31:0] wd, int acc);
    exp_t        e;
    int          sh;
    logic [31:0] old, mask, v;
    bit          mis;
    e.widx = {22'd0, a[11:2]};
    old    = ref_mem[a[11:2]];
    sh     = int'(a[1:0]) * 8;
    mis    = (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'b00);
    if (mis) begin
      e.kind = 2; e.data = ref_rdata; e.cyc = acc + 1;
    end else if (w) begin
      e.kind = 1;
      if (sz == 2'd2) begin
        v = wd; e.cyc = acc + 1;
      end else begin
        mask = ((sz == 2'd0) ? 32'h0000_00FF : 32'h0000_FFFF) << sh;
        v = (old & ~mask) | ((wd << sh) & mask);
        e.cyc = acc + 2;
      end
      ref_mem[a[11:2]] = v;
      e.data = v;
    end else begin
      v = old >> sh;
      if (sz == 2'd0) begin
        v = v & 32'hFF;
        if (sx && v[7]) v = v | 32'hFFFF_FF00;
      end else if (sz == 2'd1) begin
        v = v & 32'hFFFF;
        if (sx && v[15]) v = v | 32'hFFFF_0000;
      end
      ref_rdata = v;
      e.kind = 0; e.data = v; e.cyc = acc + 2;
    end
    q.push_back(e);
  endtask

  task automatic set_fields(logic w, logic [1:0] sz, logic sx, logic [31:0] a, logic [31:0] wd);
    cpu.req = 1'b1; cpu.we = w; cpu.size = sz; cpu.sext = sx; cpu.addr = a; cpu.wdata = wd;
  endtask

  task automatic do_op(logic w, logic [1:0] sz, logic sx, logic [31:0] a, logic [31:0] wd,
                       bit hold, bit noise, bit chk_b2b);
    int n = 0;
    @(negedge clk);
    while (!cpu.ready && n < 50) begin
      if (noise) begin
        cpu.req = 1'($urandom); cpu.we = 1'($urandom); cpu.size = 2'($urandom);
        cpu.sext = 1'($urandom); cpu.addr = $urandom; cpu.wdata = $urandom;
      end else begin
        set_fields(w, sz, sx, a, wd);
      end
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      chk("accept_timeout", 0, 1);
      cpu.req = 1'b0;
      return;
    end
    if (chk_b2b) chk("b2b_accept_cycle", cyc, last_done + 1);
    set_fields(w, sz, sx, a, wd);
    model(w, sz, sx, a, wd, cyc);
    @(posedge clk);
    #1;
    if (!hold) cpu.req = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((q.size() != 0 || !cpu.ready) && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("idle_timeout", 0, 1);
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (!rst) begin
        if (mi.dm_we && !cpu.done) chk("dm_we_without_done", 1, 0);
        if (cpu.done) begin
          last_done = cyc;
          if (q.size() == 0) begin
            chk("unexpected_done", 1, 0);
          end else begin
            e = q.pop_front();
            chk("latency", cyc, e.cyc);
            chk("err", {31'd0, cpu.err}, (e.kind == 2) ? 32'd1 : 32'd0);
            chk("dm_we", {31'd0, mi.dm_we}, (e.kind == 1) ? 32'd1 : 32'd0);
            if (e.kind == 1) begin
              chk("dm_addr", {22'd0, mi.dm_addr}, e.widx);
              chk("dm_din", mi.dm_din, e.data);
            end else begin
              chk("rdata", cpu.rdata, e.data);
            end
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int bad;
    cpu.req = 1'b0; cpu.we = 1'b0; cpu.size = 2'd0; cpu.sext = 1'b0;
    cpu.addr = '0; cpu.wdata = '0;
    for (int i = 0; i < 1024; i++) begin
      mem[i] = $urandom;
      ref_mem[i] = mem[i];
    end
    repeat (3) @(negedge clk);
    chk("reset_ready", {31'd0, cpu.ready}, 32'd1);
    chk("reset_done", {31'd0, cpu.done}, 32'd0);
    chk("reset_err", {31'd0, cpu.err}, 32'd0);
    chk("reset_dm_we", {31'd0, mi.dm_we}, 32'd0);
    chk("reset_rdata", cpu.rdata, 32'd0);
    rst = 1'b0;

    do_op(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEAD_BEEF, 0, 0, 0);
    wait_idle();
    chk("sw_mem4", mem[4], 32'hDEAD_BEEF);

    mem[4] = 32'h1122_3344; ref_mem[4] = 32'h1122_3344;
    do_op(1'b1, 2'd0, 1'b0, 32'h12, 32'h0000_00AA, 0, 0, 0);
    wait_idle();
    chk("sb_mem4", mem[4], 32'h11AA_3344);

    mem[4] = 32'h8001_F0FF; ref_mem[4] = 32'h8001_F0FF;
    do_op(1'b0, 2'd1, 1'b1, 32'h12, 32'h0, 0, 0, 0);
    wait_idle();
    chk("lh_rdata", cpu.rdata, 32'hFFFF_8001);
    do_op(1'b0, 2'd1, 1'b0, 32'h12, 32'h0, 0, 0, 0);
    wait_idle();
    chk("lhu_rdata", cpu.rdata, 32'h0000_8001);
    do_op(1'b0, 2'd0, 1'b1, 32'h10, 32'h0, 0, 0, 0);
    wait_idle();
    chk("lb_rdata", cpu.rdata, 32'hFFFF_FFFF);

    do_op(1'b0, 2'd2, 1'b0, 32'h13, 32'h0, 0, 0, 0);
    wait_idle();
    chk("err_rdata_kept", cpu.rdata, 32'hFFFF_FFFF);

    @(negedge clk);
    set_fields(1'b1, 2'd0, 1'b0, 32'h12, 32'h0000_0055);
    @(posedge clk);
    #1;
    cpu.req = 1'b0;
    rst = 1'b1;
    #1;
    chk("abort_ready", {31'd0, cpu.ready}, 32'd1);
    chk("abort_done", {31'd0, cpu.done}, 32'd0);
    chk("abort_dm_we", {31'd0, mi.dm_we}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    chk("abort_mem4", mem[4], 32'h8001_F0FF);
    rst = 1'b0;
    ref_rdata = '0;
    repeat (3) @(negedge clk);

    do_op(1'b1, 2'd0, 1'b0, 32'h21, 32'h0000_0077, 1, 0, 0);
    do_op(1'b0, 2'd2, 1'b0, 32'h20, 32'h0, 0, 0, 1);
    wait_idle();

    repeat (300) begin
      logic [31:0] a;
      a = ($urandom & 32'hFFFF_F000) | 32'($urandom_range(0, 63));
      do_op(1'($urandom), 2'($urandom), 1'($urandom), a, $urandom, 0, 1, 0);
    end
    wait_idle();

    bad = 0;
    for (int i = 0; i < 1024; i++) if (mem[i] !== ref_mem[i]) bad++;
    chk("final_mem_words_differing", bad, 0);
    chk("queue_drained", q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
